// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RISC-V style controller.
// Package name: mc_ctrl_pkg.
// Contents:
//   - state_t: FSM state encoding (the debug state output shows these values).
//   - Opcode constants for the supported instruction classes.
//   - Encodings for alu_op, imm_src, result_src, alu_src_a and alu_src_b.
//   - Helper functions for immediate-format decode and opcode legality.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format follows the opcode directly, independent of state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle.
// Parameter: STATE_W - width of the debug state output.
// Datapath -> controller: op, funct3, funct7_5, zero, mem_ready.
// Controller -> datapath: pc_write, adr_src, ir_write, mem_write, reg_write,
//   illegal, result_src, alu_src_a, alu_src_b, imm_src, alu_op, state.
// There is no valid/ready handshake: every control is a level meaning
// "this cycle". mem_ready is a level from memory saying the access in the
// current cycle completes; it only matters when MC_MEM_READY_EN is defined.
// funct3/funct7_5 travel with the bundle for the external ALU decoder and
// are not consumed by the controller.
interface multicycle_controller_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7_5;
    logic               zero;
    logic               mem_ready;

    logic               pc_write;
    logic               adr_src;
    logic               ir_write;
    logic               mem_write;
    logic               reg_write;
    logic               illegal;
    logic [1:0]         result_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         imm_src;
    logic [1:0]         alu_op;
    logic [STATE_W-1:0] state;

    // master: the controller
    modport master (
        input  op, funct3, funct7_5, zero, mem_ready,
        output pc_write, adr_src, ir_write, mem_write, reg_write, illegal,
               result_src, alu_src_a, alu_src_b, imm_src, alu_op, state
    );

    // slave: the datapath / observer
    modport slave (
        output op, funct3, funct7_5, zero, mem_ready,
        input  pc_write, adr_src, ir_write, mem_write, reg_write, illegal,
               result_src, alu_src_a, alu_src_b, imm_src, alu_op, state
    );
endinterface

// File: rtl/multicycle_controller_output_decode.sv
// mc_output_decode: combinational map from FSM state to datapath controls.
// Inputs : i_state, i_op, i_zero, i_mem_ready, i_rst_n
// Outputs: o_pc_write, o_adr_src, o_ir_write, o_mem_write, o_reg_write,
//          o_illegal, o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src,
//          o_alu_op
// Optional feature macro: MC_MEM_READY_EN (write/enable strobes in FETCH and
// MEMWRITE only fire in the cycle mem_ready=1).
module mc_output_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [6:0] i_op,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    input  logic       i_rst_n,
    output logic       o_pc_write,
    output logic       o_adr_src,
    output logic       o_ir_write,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic       o_illegal,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_imm_src,
    output logic [1:0] o_alu_op
);

    logic w_go;         // current memory access completes this cycle
    logic w_pc_update;
    logic w_branch;
    logic w_ir_write;
    logic w_mem_write;
    logic w_reg_write;
    logic w_illegal;

`ifdef MC_MEM_READY_EN
    assign w_go = i_mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = i_mem_ready;
    assign w_go = 1'b1;
`endif

    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        o_adr_src    = 1'b0;
        o_result_src = RES_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RD2;
        o_alu_op     = ALU_OP_ADD;
        case (i_state)
            S_FETCH: begin
                w_ir_write   = w_go;
                w_pc_update  = w_go;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
                w_illegal   = !op_supported(i_op);
            end
            S_MEMADR: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                o_adr_src = 1'b1;
            end
            S_MEMWB: begin
                o_result_src = RES_DATA;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o_adr_src   = 1'b1;
                w_mem_write = w_go;
            end
            S_EXECR: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_op    = ALU_OP_FUNCT;
            end
            S_EXECI: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_JAL: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_op    = ALU_OP_SUB;
                w_branch    = 1'b1;
            end
            default: ;  // unused encodings: everything stays 0
        endcase
    end

    // State is already FETCH while reset is low; only the strobes need
    // suppressing so nothing is written during reset.
    assign o_pc_write  = i_rst_n & (w_pc_update | (w_branch & i_zero));
    assign o_ir_write  = i_rst_n & w_ir_write;
    assign o_mem_write = i_rst_n & w_mem_write;
    assign o_reg_write = i_rst_n & w_reg_write;
    assign o_illegal   = i_rst_n & w_illegal;
    assign o_imm_src   = imm_src_of(i_op);

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RISC-V datapath.
// Parameter: STATE_W - width of the debug state output.
// Ports    : clk, rst_n (async active-low), bus (multicycle_controller_if.master)
// Holds the state register and next-state logic; control decode lives in
// mc_output_decode. The ALU decoder is external.
// Optional feature macro: MC_MEM_READY_EN - FETCH, MEMREAD and MEMWRITE wait
// for mem_ready=1 before advancing. Undefined: mem_ready is ignored.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    multicycle_controller_if.master bus
);

    state_t r_state;
    logic   w_go;

`ifdef MC_MEM_READY_EN
    assign w_go = bus.mem_ready;
`else
    assign w_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (w_go) r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXECR;
                        OP_ITYPE:     r_state <= S_EXECI;
                        OP_JAL:       r_state <= S_JAL;
                        OP_BEQ:       r_state <= S_BEQ;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   r_state <= (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (w_go) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (w_go) r_state <= S_FETCH;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_BEQ:      r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    assign bus.state = STATE_W'(r_state);

    mc_output_decode u_decode (
        .i_state      (r_state),
        .i_op         (bus.op),
        .i_zero       (bus.zero),
        .i_mem_ready  (bus.mem_ready),
        .i_rst_n      (rst_n),
        .o_pc_write   (bus.pc_write),
        .o_adr_src    (bus.adr_src),
        .o_ir_write   (bus.ir_write),
        .o_mem_write  (bus.mem_write),
        .o_reg_write  (bus.reg_write),
        .o_illegal    (bus.illegal),
        .o_result_src (bus.result_src),
        .o_alu_src_a  (bus.alu_src_a),
        .o_alu_src_b  (bus.alu_src_b),
        .o_imm_src    (bus.imm_src),
        .o_alu_op     (bus.alu_op)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. Observed vector layout (20 bits):
// {state[3:0], pc_write, adr_src, ir_write, mem_write, reg_write, illegal,
//  result_src, alu_src_a, alu_src_b, imm_src, alu_op}
module tb_multicycle_controller;

    localparam bit MR_EN =
`ifdef MC_MEM_READY_EN
        1'b1;
`else
        1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if #(.STATE_W(4)) bus ();

    multicycle_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wire [19:0] act = {bus.state, bus.pc_write, bus.adr_src, bus.ir_write,
                       bus.mem_write, bus.reg_write, bus.illegal,
                       bus.result_src, bus.alu_src_a, bus.alu_src_b,
                       bus.imm_src, bus.alu_op};

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];
    string       name_q[$];

    // ---------------- expected-value model ----------------
    function automatic logic [1:0] tb_imm(input logic [6:0] op);
        case (op)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic tb_legal(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011;
    endfunction

    function automatic logic [19:0] exp_vec(input int st, input logic [6:0] op,
                                            input logic zero, input logic mr);
        logic pcw, adr, irw, mw, rw, ill, go;
        logic [1:0] rs, sa, sb, ao;
        go = MR_EN ? mr : 1'b1;
        {pcw, adr, irw, mw, rw, ill} = 6'b0;
        {rs, sa, sb, ao} = 8'b0;
        case (st)
            0:  begin irw = go; pcw = go; sb = 2'b10; rs = 2'b10; end
            1:  begin sa = 2'b01; sb = 2'b01; ill = !tb_legal(op); end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  begin adr = 1'b1; end
            4:  begin rs = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = go; end
            6:  begin sa = 2'b10; ao = 2'b10; end
            7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            8:  begin rw = 1'b1; end
            9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            10: begin sa = 2'b10; ao = 2'b01; pcw = zero; end
            default: ;
        endcase
        return {4'(st), pcw, adr, irw, mw, rw, ill, rs, sa, sb, tb_imm(op), ao};
    endfunction

    function automatic int next_st(input int st, input logic [6:0] op, input logic mr);
        logic hold;
        hold = MR_EN && !mr;
        case (st)
            0:  return hold ? 0 : 1;
            1: begin
                case (op)
                    7'b0000011, 7'b0100011: return 2;
                    7'b0110011:             return 6;
                    7'b0010011:             return 7;
                    7'b1101111:             return 9;
                    7'b1100011:             return 10;
                    default:                return 0;
                endcase
            end
            2:  return (op == 7'b0000011) ? 3 : 5;
            3:  return hold ? 3 : 4;
            5:  return hold ? 5 : 0;
            6, 7, 9: return (st == 9) ? 8 : 8;
            default: return 0;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_now(input string nm, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", nm, act, exp);
        end
    endtask

    // Monitor: every cycle with outstanding expectations is compared.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [19:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %05h expected %05h (state got %0d exp %0d)",
                         nm, act, e, act[19:16], e[19:16]);
            end
        end
    end

    // ---------------- driver ----------------
    // Called #1 after a rising edge with the DUT in FETCH. mem_ready is
    // pulled low for stall_n cycles while the walk is in stall_st.
    task automatic run_instr(input string nm, input logic [6:0] op, input logic zero,
                             input int exp_lat, input int stall_st, input int stall_n);
        int st, cycles, stalls, total;
        logic mr;
        bus.op = op;
        bus.zero = zero;
        st = 0;
        cycles = 0;
        stalls = stall_n;
        do begin
            mr = !(st == stall_st && stalls > 0);
            if (!mr) stalls--;
            bus.mem_ready = mr;
            exp_q.push_back(exp_vec(st, op, zero, mr));
            name_q.push_back($sformatf("%s_c%0d", nm, cycles));
            st = next_st(st, op, mr);
            @(posedge clk);
            #1;
            cycles++;
        end while (st != 0 && cycles < 20);
        bus.mem_ready = 1'b1;
        total = exp_lat + (MR_EN ? stall_n : 0);
        checks++;
        if (cycles != total || bus.state !== 4'd0) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles state %0d expected %0d cycles state 0",
                     nm, cycles, bus.state, total);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.op        = 7'b0000011;
        bus.funct3    = 3'b000;
        bus.funct7_5  = 1'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #3;
        // In reset: FETCH values with strobes off; lw -> imm_src 00
        check_now("reset_init", {4'd0, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr("lw",      7'b0000011, 1'b0, 5, -1, 0);
        run_instr("sw",      7'b0100011, 1'b0, 4, -1, 0);
        run_instr("rtype",   7'b0110011, 1'b1, 4, -1, 0);
        run_instr("itype",   7'b0010011, 1'b0, 4, -1, 0);
        run_instr("jal",     7'b1101111, 1'b0, 4, -1, 0);
        run_instr("beq_z1",  7'b1100011, 1'b1, 3, -1, 0);
        run_instr("beq_z0",  7'b1100011, 1'b0, 3, -1, 0);
        run_instr("ecall",   7'b1110011, 1'b0, 2, -1, 0);
        run_instr("op_zero", 7'b0000000, 1'b1, 2, -1, 0);
        run_instr("sw_stall",  7'b0100011, 1'b0, 4, 5, 3);
        run_instr("lw_fstall", 7'b0000011, 1'b0, 5, 0, 2);
        run_instr("lw_rstall", 7'b0000011, 1'b0, 5, 3, 1);

        // Asynchronous reset in the middle of MEMADR of a sw
        bus.op = 7'b0100011;
        bus.zero = 1'b1;
        exp_q.push_back(exp_vec(0, 7'b0100011, 1'b1, 1'b1));
        name_q.push_back("rst_pre_fetch");
        @(posedge clk);
        #1;
        exp_q.push_back(exp_vec(1, 7'b0100011, 1'b1, 1'b1));
        name_q.push_back("rst_pre_decode");
        @(posedge clk);
        #1;
        check_now("rst_in_memadr", {4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00});
        #2;
        rst_n = 1'b0;
        #1;
        check_now("rst_async", {4'd0, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00});
        @(posedge clk);
        #1;
        check_now("rst_held", {4'd0, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00});
        rst_n = 1'b1;
        run_instr("lw_after_rst", 7'b0000011, 1'b0, 5, -1, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
